// File: rtl/fifo_sc_flags.sv
// fifo_sc_flags
// Single-clock FIFO for buffering commands/data between pipeline stages in
// one clock domain. It provides an occupancy count, programmable almost-full
// and almost-empty flags, a selectable first-word-fall-through read mode and
// sticky overflow/underflow error flags.
//
// Ports:
//   Clk         - clock, all state changes on the rising edge
//   Reset       - asynchronous active-high reset
//   Data        - write data (WIDTH bits)
//   WrEn        - write request, accepted only when not Full
//   RdEn        - read request (standard mode) / pop acknowledge (FWFT mode)
//   ClrErr      - synchronous clear of Overflow and Underflow
//   Q           - read data (WIDTH bits)
//   Empty       - occupancy is zero
//   Full        - occupancy equals DEPTH
//   AlmostEmpty - occupancy <= AE_LEVEL
//   AlmostFull  - occupancy >= AF_LEVEL
//   Cnt         - current occupancy ($clog2(DEPTH)+1 bits)
//   Overflow    - sticky, set by a write attempted while Full
//   Underflow   - sticky, set by a read attempted while Empty
module fifo_sc_flags #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         Data,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic                     ClrErr,
  output logic [WIDTH-1:0]         Q,
  output logic                     Empty,
  output logic                     Full,
  output logic                     AlmostEmpty,
  output logic                     AlmostFull,
  output logic [$clog2(DEPTH):0]   Cnt,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Reject illegal configurations while elaborating instead of building a
  // FIFO whose pointer wrap or flag thresholds would silently misbehave.
  if (WIDTH < 1) begin : gen_bad_width
    $error("fifo_sc_flags: WIDTH must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("fifo_sc_flags: DEPTH must be a power of two and at least 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : gen_bad_af
    $error("fifo_sc_flags: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : gen_bad_ae
    $error("fifo_sc_flags: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          ovf_q,   ovf_d;
  logic          udf_q,   udf_d;
  logic          wrOk;
  logic          rdOk;

  // Status flags are decoded straight from the registered count, so they
  // move on the same edge as Cnt and never look ahead at this cycle's access.
  assign Empty       = (cnt_q == '0);
  assign Full        = (cnt_q == DEPTH_C);
  assign AlmostEmpty = (cnt_q <= AE_C);
  assign AlmostFull  = (cnt_q >= AF_C);
  assign Cnt         = cnt_q;
  assign Overflow    = ovf_q;
  assign Underflow   = udf_q;

  // Accept decisions and next-state computation. Accesses are judged against
  // the current registered flags only, so a write while Full is dropped even
  // if a read frees a slot in the same cycle, and a read while Empty is
  // dropped even if a write lands in the same cycle. Pointers wrap for free
  // because DEPTH is a power of two. For the sticky errors the clear is
  // applied first so that a fresh error in the same cycle wins.
  always_comb begin
    wrOk    = WrEn && !Full;
    rdOk    = RdEn && !Empty;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (wrOk) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (rdOk) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(wrOk) - CW'(rdOk);

    if (ClrErr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (WrEn && Full) begin
      ovf_d = 1'b1;
    end
    if (RdEn && Empty) begin
      udf_d = 1'b1;
    end
  end

  // Control state register. Reset empties the FIFO at once by clearing the
  // pointers and count; the storage itself is left untouched.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array, written only on accepted writes. It has no reset so it
  // can map onto plain RAM; stale words are unreachable once the pointers
  // are cleared.
  always_ff @(posedge Clk) begin
    if (wrOk && !Reset) begin
      mem[wrPtr_q] <= Data;
    end
  end

  if (FWFT == 0) begin : gen_std_read
    logic [WIDTH-1:0] q_q, q_d;

    // Standard read: the head word is captured on an accepted read and held
    // otherwise, including across rejected reads.
    always_comb begin
      q_d = q_q;
      if (rdOk) begin
        q_d = mem[rdPtr_q];
      end
    end

    // Output data register for standard mode.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end

    assign Q = q_q;
  end else begin : gen_fwft_read
    // Fall-through read: the head word is shown whenever the FIFO holds
    // data, and RdEn merely pops it. An empty FIFO presents zero.
    assign Q = Empty ? '0 : mem[rdPtr_q];
  end

endmodule

// File: tb/tb_fifo_sc_flags.sv
// tb_fifo_sc_flags
// Self-checking bench for fifo_sc_flags. One instance runs in standard read
// mode and is checked by a read-data scoreboard plus directed status checks;
// a second instance runs in first-word-fall-through mode.
module tb_fifo_sc_flags;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] dataA, qA;
  logic       wrA, rdA, clrA;
  logic       emptyA, fullA, aeA, afA, ovfA, udfA;
  logic [2:0] cntA;

  logic [7:0] dataB, qB;
  logic       wrB, rdB, clrB;
  logic       emptyB, fullB, aeB, afB, ovfB, udfB;
  logic [2:0] cntB;

  logic [7:0] expQ [$];
  int         compared   = 0;
  int         mismatched = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  fifo_sc_flags #(
    .WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dutStd (
    .Clk(clk), .Reset(reset), .Data(dataA), .WrEn(wrA), .RdEn(rdA),
    .ClrErr(clrA), .Q(qA), .Empty(emptyA), .Full(fullA),
    .AlmostEmpty(aeA), .AlmostFull(afA), .Cnt(cntA),
    .Overflow(ovfA), .Underflow(udfA)
  );

  fifo_sc_flags #(
    .WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dutFwft (
    .Clk(clk), .Reset(reset), .Data(dataB), .WrEn(wrB), .RdEn(rdB),
    .ClrErr(clrB), .Q(qB), .Empty(emptyB), .Full(fullB),
    .AlmostEmpty(aeB), .AlmostFull(afB), .Cnt(cntB),
    .Overflow(ovfB), .Underflow(udfB)
  );

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the standard instance: inputs change on the falling
  // edge, and the task returns just after the following rising edge.
  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic clr, input logic [7:0] d);
    @(negedge clk);
    wrA   = wr;
    rdA   = rd;
    clrA  = clr;
    dataA = d;
    @(posedge clk);
    #1;
  endtask

  // Same cycle driver for the FWFT instance.
  task automatic applyStimulusB(input logic wr, input logic rd,
                                input logic [7:0] d);
    @(negedge clk);
    wrB   = wr;
    rdB   = rd;
    dataB = d;
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {Full, AlmostFull, AlmostEmpty, Empty, Overflow, Underflow}.
  task automatic checkStatus(input string name, input int expCnt,
                             input logic [5:0] expFlags);
    checkOutput({name, " cnt"}, 32'(cntA), 32'(expCnt));
    checkOutput({name, " flags"}, 32'({fullA, afA, aeA, emptyA, ovfA, udfA}),
                32'(expFlags));
  endtask

  // Issue an accepted read on the standard instance and queue its word.
  task automatic readExpect(input logic [7:0] d);
    expQ.push_back(d);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    wrA = 0; rdA = 0; clrA = 0; dataA = 0;
    wrB = 0; rdB = 0; clrB = 0; dataB = 0;

    // Monitor: whenever the standard instance accepts a read at an edge,
    // the word it presents shortly after is matched against the scoreboard.
    fork
      begin : monitor
        forever begin
          bit pres;
          @(posedge clk);
          pres = rdA && !emptyA && !reset;
          #2;
          if (pres) begin
            if (expQ.size() == 0) begin
              compared++;
              mismatched++;
              $display("[TB] FAIL read data unexpected: got 0x%0h, expected no read", qA);
            end else begin
              checkOutput("read data", 32'(qA), 32'(expQ.pop_front()));
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkStatus("reset", 0, 6'b001100);
    checkOutput("reset q", 32'(qA), 32'h0);

    // Mid-operation reset discards contents and clears Q at once.
    applyStimulus(1, 0, 0, 8'h11);
    applyStimulus(1, 0, 0, 8'h22);
    applyStimulus(1, 0, 0, 8'h33);
    readExpect(8'h11);
    #2;
    wrA = 0; rdA = 0;
    reset = 1'b1;
    #1;
    checkStatus("async reset", 0, 6'b001100);
    checkOutput("async reset q", 32'(qA), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1, 0, 8'h00);
    checkStatus("read after reset", 0, 6'b001101);
    checkOutput("read after reset q", 32'(qA), 32'h0);
    applyStimulus(0, 0, 1, 8'h00);
    checkStatus("clear after reset", 0, 6'b001100);

    // Fill to Full, then overflow.
    applyStimulus(1, 0, 0, 8'h01);  checkStatus("fill 1", 1, 6'b001000);
    applyStimulus(1, 0, 0, 8'h02);  checkStatus("fill 2", 2, 6'b000000);
    applyStimulus(1, 0, 0, 8'h03);  checkStatus("fill 3", 3, 6'b010000);
    applyStimulus(1, 0, 0, 8'h04);  checkStatus("fill 4", 4, 6'b110000);
    applyStimulus(1, 0, 0, 8'h05);  checkStatus("overflow", 4, 6'b110010);

    // Drain past empty.
    readExpect(8'h01);  checkStatus("drain 1", 3, 6'b010010);
    readExpect(8'h02);  checkStatus("drain 2", 2, 6'b000010);
    readExpect(8'h03);  checkStatus("drain 3", 1, 6'b001010);
    readExpect(8'h04);  checkStatus("drain 4", 0, 6'b001110);
    applyStimulus(0, 1, 0, 8'h00);
    checkStatus("underflow", 0, 6'b001111);
    checkOutput("underflow q hold", 32'(qA), 32'h04);
    applyStimulus(0, 0, 1, 8'h00);
    checkStatus("clrerr", 0, 6'b001100);

    // Simultaneous write and read at mid, full and empty.
    applyStimulus(1, 0, 0, 8'h10);
    applyStimulus(1, 0, 0, 8'h20);
    expQ.push_back(8'h10);
    applyStimulus(1, 1, 0, 8'h30);  checkStatus("both at 2", 2, 6'b000000);
    applyStimulus(1, 0, 0, 8'h40);
    applyStimulus(1, 0, 0, 8'h50);  checkStatus("refill", 4, 6'b110000);
    expQ.push_back(8'h20);
    applyStimulus(1, 1, 0, 8'h60);  checkStatus("both at full", 3, 6'b010010);
    readExpect(8'h30);
    readExpect(8'h40);
    readExpect(8'h50);              checkStatus("drain after full", 0, 6'b001110);
    applyStimulus(1, 1, 0, 8'h70);  checkStatus("both at empty", 1, 6'b001011);
    readExpect(8'h70);              checkStatus("read written", 0, 6'b001111);
    applyStimulus(0, 0, 1, 8'h00);

    // Streaming with occupancy held at 2 across several pointer wraps.
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h01);
    for (int i = 2; i < 16; i++) begin
      expQ.push_back(8'(i - 2));
      applyStimulus(1, 1, 0, 8'(i));
      checkStatus($sformatf("wrap %0d", i), 2, 6'b000000);
    end
    readExpect(8'h0E);
    readExpect(8'h0F);
    applyStimulus(0, 0, 0, 8'h00);
    checkStatus("wrap end", 0, 6'b001100);

    // First-word-fall-through instance.
    checkOutput("fwft idle q", 32'(qB), 32'h0);
    applyStimulusB(1, 0, 8'hA5);
    checkOutput("fwft first q", 32'(qB), 32'hA5);
    checkOutput("fwft first empty", 32'(emptyB), 32'h0);
    applyStimulusB(1, 0, 8'h5A);
    checkOutput("fwft head held", 32'(qB), 32'hA5);
    checkOutput("fwft cnt 2", 32'(cntB), 32'h2);
    applyStimulusB(0, 1, 8'h00);
    checkOutput("fwft pop 1 q", 32'(qB), 32'h5A);
    applyStimulusB(0, 1, 8'h00);
    checkOutput("fwft pop 2 q", 32'(qB), 32'h0);
    checkOutput("fwft pop 2 empty", 32'(emptyB), 32'h1);
    applyStimulusB(0, 0, 8'h00);

    // Allow the monitor a bounded time to consume anything outstanding.
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
